// File: rtl/rtc_edit_controller.sv
// ---------------------------------------------------------------------------
// rtc_edit_controller
//
// Front-panel editing controller for the RTC. It owns the edit group
// (chronometer / time / date), the cursor inside that group, and a shadow copy
// of the ten editable fields. Up/down edits wrap per field. A save commits the
// active group's fields one by one over a req/ack write handshake.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   btn_mode/left/right/up/down/save
//                         one-cycle debounced button pulses
//   load_valid/addr/data  shadow load from the RTC read path (IDLE only)
//   wr_ack                RTC interface accepted the current write
//   wr_req/addr/data      write request to the RTC interface
//   camb_crono/hora/fecha group currently being edited (one-hot, 0 in IDLE)
//   cursor_addr           field address under the cursor (0 in IDLE)
//   field_data            shadow value at cursor_addr (0 in IDLE)
//   busy                  commit sequence in progress
// All outputs are registered.
// ---------------------------------------------------------------------------
module rtc_edit_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_save,
  input  logic       load_valid,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       wr_ack,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       camb_crono,
  output logic       camb_hora,
  output logic       camb_fecha,
  output logic [7:0] cursor_addr,
  output logic [7:0] field_data,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_COMMIT_REQ,
    ST_COMMIT_GAP
  } state_t;

  typedef enum logic [1:0] {
    GRP_CRONO,
    GRP_HORA,
    GRP_FECHA
  } group_t;

  // ---- field map ----------------------------------------------------------
  function automatic logic [7:0] field_max(input logic [3:0] a);
    case (a)
      4'd1, 4'd5:              field_max = 8'd23;
      4'd2, 4'd3, 4'd6, 4'd7:  field_max = 8'd59;
      4'd4, 4'd10:             field_max = 8'd99;
      4'd8:                    field_max = 8'd31;
      4'd9:                    field_max = 8'd12;
      default:                 field_max = 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] field_min(input logic [3:0] a);
    field_min = (a == 4'd8 || a == 4'd9) ? 8'd1 : 8'd0;
  endfunction

  function automatic logic [3:0] grp_first(input group_t g);
    case (g)
      GRP_HORA:  grp_first = 4'd5;
      GRP_FECHA: grp_first = 4'd8;
      default:   grp_first = 4'd1;
    endcase
  endfunction

  function automatic logic [3:0] grp_last(input group_t g);
    case (g)
      GRP_HORA:  grp_last = 4'd7;
      GRP_FECHA: grp_last = 4'd10;
      default:   grp_last = 4'd4;
    endcase
  endfunction

  // ---- state --------------------------------------------------------------
  state_t     state_q, state_d;
  group_t     group_q, group_d;
  logic [3:0] cursor_q, cursor_d;   // kept in 1..10 so shadow indexing stays valid
  logic [3:0] idx_q, idx_d;         // field currently being committed
  logic [7:0] shadow_q [1:10];
  logic [7:0] shadow_d [1:10];

  logic       wr_req_q, wr_req_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [2:0] camb_q, camb_d;       // {crono, hora, fecha}
  logic [7:0] cursor_addr_q, cursor_addr_d;
  logic [7:0] field_data_q, field_data_d;
  logic       busy_q, busy_d;

  logic [7:0] cur_val, cur_min, cur_max;
  logic [3:0] g_first, g_last;
  logic [3:0] load_idx;
  logic [7:0] load_max;

  assign cur_val  = shadow_q[cursor_q];
  assign cur_min  = field_min(cursor_q);
  assign cur_max  = field_max(cursor_q);
  assign g_first  = grp_first(group_q);
  assign g_last   = grp_last(group_q);
  assign load_idx = load_addr[3:0];
  assign load_max = field_max(load_idx);

  // ---- next state ---------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    group_d  = group_q;
    cursor_d = cursor_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;

    case (state_q)
      ST_IDLE: begin
        if (load_valid && load_addr >= 8'd1 && load_addr <= 8'd10) begin
          // Any value above the field max is forced to the max.
          shadow_d[load_idx] = (load_data > load_max) ? load_max : load_data;
        end
        if (btn_mode) begin
          state_d  = ST_EDIT;
          group_d  = GRP_CRONO;
          cursor_d = 4'd1;
        end
      end

      ST_EDIT: begin
        // Strict priority: only the highest-priority pulse acts this cycle.
        if (btn_save) begin
          state_d = ST_COMMIT_REQ;
          idx_d   = g_first;
        end else if (btn_mode) begin
          case (group_q)
            GRP_CRONO: begin
              group_d  = GRP_HORA;
              cursor_d = 4'd5;
            end
            GRP_HORA: begin
              group_d  = GRP_FECHA;
              cursor_d = 4'd8;
            end
            default: begin
              state_d  = ST_IDLE;
              group_d  = GRP_CRONO;
              cursor_d = 4'd1;
            end
          endcase
        end else if (btn_up) begin
          shadow_d[cursor_q] = (cur_val >= cur_max) ? cur_min : cur_val + 8'd1;
        end else if (btn_down) begin
          shadow_d[cursor_q] = (cur_val <= cur_min) ? cur_max : cur_val - 8'd1;
        end else if (btn_right) begin
          cursor_d = (cursor_q == g_last) ? g_first : cursor_q + 4'd1;
        end else if (btn_left) begin
          cursor_d = (cursor_q == g_first) ? g_last : cursor_q - 4'd1;
        end
      end

      ST_COMMIT_REQ: begin
        if (wr_ack) begin
          state_d = (idx_q == g_last) ? ST_IDLE : ST_COMMIT_GAP;
        end
      end

      ST_COMMIT_GAP: begin
        idx_d   = idx_q + 4'd1;
        state_d = ST_COMMIT_REQ;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---- registered outputs, derived from next-state values ----------------
  always_comb begin
    wr_req_d      = (state_d == ST_COMMIT_REQ);
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    busy_d        = (state_d == ST_COMMIT_REQ) || (state_d == ST_COMMIT_GAP);
    camb_d        = 3'b000;
    cursor_addr_d = 8'd0;
    field_data_d  = 8'd0;

    // Address/data only change on entry to a request, so they are stable
    // while wr_req is high. The shadow is frozen while busy.
    if (state_d == ST_COMMIT_REQ) begin
      wr_addr_d = {4'd0, idx_d};
      wr_data_d = shadow_q[idx_d];
    end

    if (state_d != ST_IDLE) begin
      camb_d[2]     = (group_d == GRP_CRONO);
      camb_d[1]     = (group_d == GRP_HORA);
      camb_d[0]     = (group_d == GRP_FECHA);
      cursor_addr_d = {4'd0, cursor_d};
      field_data_d  = shadow_d[cursor_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      group_q       <= GRP_CRONO;
      cursor_q      <= 4'd1;
      idx_q         <= 4'd1;
      for (int i = 1; i <= 10; i++) begin
        shadow_q[i] <= (i == 8 || i == 9) ? 8'd1 : 8'd0;
      end
      wr_req_q      <= 1'b0;
      wr_addr_q     <= 8'd0;
      wr_data_q     <= 8'd0;
      camb_q        <= 3'b000;
      cursor_addr_q <= 8'd0;
      field_data_q  <= 8'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      group_q       <= group_d;
      cursor_q      <= cursor_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      wr_req_q      <= wr_req_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      camb_q        <= camb_d;
      cursor_addr_q <= cursor_addr_d;
      field_data_q  <= field_data_d;
      busy_q        <= busy_d;
    end
  end

  assign wr_req      = wr_req_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign camb_crono  = camb_q[2];
  assign camb_hora   = camb_q[1];
  assign camb_fecha  = camb_q[0];
  assign cursor_addr = cursor_addr_q;
  assign field_data  = field_data_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rtc_edit_controller.sv
// ---------------------------------------------------------------------------
// tb_rtc_edit_controller
//
// Directed testbench for rtc_edit_controller: a table of single-cycle
// button/load vectors with hand-computed expected outputs, followed by
// hand-written multi-cycle sequences for commit handshakes and reset.
// ---------------------------------------------------------------------------
module tb_rtc_edit_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_left, btn_right, btn_up, btn_down, btn_save;
  logic       load_valid;
  logic [7:0] load_addr, load_data;
  logic       wr_ack;
  logic       wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       camb_crono, camb_hora, camb_fecha;
  logic [7:0] cursor_addr, field_data;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  rtc_edit_controller dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_save   (btn_save),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .wr_ack     (wr_ack),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .camb_crono (camb_crono),
    .camb_hora  (camb_hora),
    .camb_fecha (camb_fecha),
    .cursor_addr(cursor_addr),
    .field_data (field_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Button encoding {save, mode, up, down, right, left}
  localparam logic [5:0] B_SAVE = 6'b100000;
  localparam logic [5:0] B_MODE = 6'b010000;
  localparam logic [5:0] B_UP   = 6'b001000;
  localparam logic [5:0] B_DN   = 6'b000100;
  localparam logic [5:0] B_RT   = 6'b000010;
  localparam logic [5:0] B_LT   = 6'b000001;
  localparam logic [5:0] B_NONE = 6'b000000;
  // camb encoding {crono, hora, fecha}
  localparam logic [2:0] G_C = 3'b100;
  localparam logic [2:0] G_H = 3'b010;
  localparam logic [2:0] G_F = 3'b001;
  localparam logic [2:0] G_0 = 3'b000;

  typedef struct {
    logic [5:0] btn;
    logic       lv;
    logic [7:0] la;
    logic [7:0] ld;
    logic [2:0] camb;
    logic [7:0] cur;
    logic [7:0] fd;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input logic [5:0] b, input logic lv, input logic [7:0] la,
                              input logic [7:0] ld, input logic [2:0] c,
                              input logic [7:0] cur, input logic [7:0] fd);
    vec_t v;
    v.btn = b; v.lv = lv; v.la = la; v.ld = ld; v.camb = c; v.cur = cur; v.fd = fd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_btn(input logic [5:0] b);
    {btn_save, btn_mode, btn_up, btn_down, btn_right, btn_left} = b;
  endtask

  task automatic clear_in();
    drive_btn(B_NONE);
    load_valid = 1'b0;
    load_addr  = 8'd0;
    load_data  = 8'd0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " wr_req"},  {31'd0, wr_req}, 32'd0);
    chk({tag, " wr_addr"}, {24'd0, wr_addr}, 32'd0);
    chk({tag, " wr_data"}, {24'd0, wr_data}, 32'd0);
    chk({tag, " camb"},    {29'd0, camb_crono, camb_hora, camb_fecha}, 32'd0);
    chk({tag, " cursor"},  {24'd0, cursor_addr}, 32'd0);
    chk({tag, " field"},   {24'd0, field_data}, 32'd0);
    chk({tag, " busy"},    {31'd0, busy}, 32'd0);
  endtask

  // Apply one button pulse and check group/cursor/field afterwards.
  task automatic pulse_chk(input string name, input logic [5:0] b, input logic [2:0] c,
                           input logic [7:0] cur, input logic [7:0] fd);
    drive_btn(b);
    tick();
    drive_btn(B_NONE);
    chk({name, " camb"},   {29'd0, camb_crono, camb_hora, camb_fecha}, {29'd0, c});
    chk({name, " cursor"}, {24'd0, cursor_addr}, {24'd0, cur});
    chk({name, " field"},  {24'd0, field_data}, {24'd0, fd});
  endtask

  logic [7:0] exp_d [3];
  int         cnt;

  initial begin
    reset  = 1'b1;
    wr_ack = 1'b0;
    clear_in();

    // ---- table of single-cycle vectors ----
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_C, 1, 0));
    vecs.push_back(mk(B_UP,   0, 0, 0,   G_C, 1, 1));
    vecs.push_back(mk(B_UP,   0, 0, 0,   G_C, 1, 2));
    vecs.push_back(mk(B_UP,   0, 0, 0,   G_C, 1, 3));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_H, 5, 0));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_F, 8, 1));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_0, 0, 0));
    vecs.push_back(mk(B_NONE, 1, 6, 59,  G_0, 0, 0));   // load min=59 in IDLE
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_C, 1, 3));   // edits kept
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_H, 5, 0));
    vecs.push_back(mk(B_RT,   0, 0, 0,   G_H, 6, 59));
    vecs.push_back(mk(B_UP,   0, 0, 0,   G_H, 6, 0));   // 59 -> 0
    vecs.push_back(mk(B_DN,   0, 0, 0,   G_H, 6, 59));  // 0 -> 59
    vecs.push_back(mk(B_LT,   0, 0, 0,   G_H, 5, 0));
    vecs.push_back(mk(B_LT,   0, 0, 0,   G_H, 7, 0));   // 5 -> 7
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_F, 8, 1));
    vecs.push_back(mk(B_RT,   0, 0, 0,   G_F, 9, 1));
    vecs.push_back(mk(B_DN,   0, 0, 0,   G_F, 9, 12));  // month 1 -> 12
    vecs.push_back(mk(B_LT,   0, 0, 0,   G_F, 8, 1));
    vecs.push_back(mk(B_DN,   0, 0, 0,   G_F, 8, 31));  // day 1 -> 31
    vecs.push_back(mk(B_UP,   0, 0, 0,   G_F, 8, 1));   // day 31 -> 1
    vecs.push_back(mk(B_NONE, 1, 8, 20,  G_F, 8, 1));   // load ignored in EDIT
    vecs.push_back(mk(B_UP | B_DN | B_RT, 0, 0, 0, G_F, 8, 2));
    vecs.push_back(mk(B_LT | B_RT, 0, 0, 0, G_F, 9, 12));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_0, 0, 0));
    vecs.push_back(mk(B_NONE, 1, 10, 150, G_0, 0, 0));  // clamped to 99
    vecs.push_back(mk(B_NONE, 1, 11, 5,  G_0, 0, 0));   // bad address
    vecs.push_back(mk(B_NONE, 1, 7, 30,  G_0, 0, 0));
    vecs.push_back(mk(B_NONE, 1, 7, 45,  G_0, 0, 0));   // last wins
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_C, 1, 3));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_H, 5, 0));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_F, 8, 2));
    vecs.push_back(mk(B_LT,   0, 0, 0,   G_F, 10, 99));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_0, 0, 0));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_C, 1, 3));
    vecs.push_back(mk(B_MODE, 0, 0, 0,   G_H, 5, 0));
    vecs.push_back(mk(B_LT,   0, 0, 0,   G_H, 7, 45));

    // ---- reset ----
    tick();
    tick();
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive_btn(vecs[i].btn);
      load_valid = vecs[i].lv;
      load_addr  = vecs[i].la;
      load_data  = vecs[i].ld;
      tick();
      clear_in();
      chk($sformatf("v%0d camb", i), {29'd0, camb_crono, camb_hora, camb_fecha},
          {29'd0, vecs[i].camb});
      chk($sformatf("v%0d cursor", i), {24'd0, cursor_addr}, {24'd0, vecs[i].cur});
      chk($sformatf("v%0d field", i), {24'd0, field_data}, {24'd0, vecs[i].fd});
      chk($sformatf("v%0d busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d wr_req", i), {31'd0, wr_req}, 32'd0);
    end

    // ---- HORA commit, ack delayed 3 cycles per write ----
    exp_d[0] = 8'd0;
    exp_d[1] = 8'd59;
    exp_d[2] = 8'd45;
    drive_btn(B_SAVE);
    tick();
    drive_btn(B_NONE);
    chk("save busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("w%0d req", k), {31'd0, wr_req}, 32'd1);
      chk($sformatf("w%0d addr", k), {24'd0, wr_addr}, 5 + k);
      chk($sformatf("w%0d data", k), {24'd0, wr_data}, {24'd0, exp_d[k]});
      for (int w = 0; w < 3; w++) begin
        if (k == 0 && w == 0) btn_mode = 1'b1;   // must be ignored while busy
        tick();
        btn_mode = 1'b0;
        chk($sformatf("w%0d hold%0d req", k, w), {31'd0, wr_req}, 32'd1);
        chk($sformatf("w%0d hold%0d addr", k, w), {24'd0, wr_addr}, 5 + k);
        chk($sformatf("w%0d hold%0d data", k, w), {24'd0, wr_data}, {24'd0, exp_d[k]});
        chk($sformatf("w%0d hold%0d hora", k, w), {31'd0, camb_hora}, 32'd1);
      end
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      chk($sformatf("w%0d ack req", k), {31'd0, wr_req}, 32'd0);
      if (k < 2) begin
        chk($sformatf("w%0d gap busy", k), {31'd0, busy}, 32'd1);
        tick();
      end else begin
        chk("commit end busy", {31'd0, busy}, 32'd0);
        chk("commit end camb", {29'd0, camb_crono, camb_hora, camb_fecha}, 32'd0);
        chk("commit end cursor", {24'd0, cursor_addr}, 32'd0);
      end
    end

    // ---- HORA commit with ack held high: busy spans 5 cycles ----
    pulse_chk("ia mode1", B_MODE, G_C, 1, 3);
    pulse_chk("ia mode2", B_MODE, G_H, 5, 0);
    wr_ack = 1'b1;
    drive_btn(B_SAVE);
    tick();
    drive_btn(B_NONE);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      cnt++;
      tick();
    end
    wr_ack = 1'b0;
    chk("immediate ack busy cycles", cnt, 32'd5);
    chk("immediate ack end camb", {29'd0, camb_crono, camb_hora, camb_fecha}, 32'd0);

    // ---- reset while waiting for ack ----
    pulse_chk("rs mode1", B_MODE, G_C, 1, 3);
    pulse_chk("rs mode2", B_MODE, G_H, 5, 0);
    drive_btn(B_SAVE);
    tick();
    drive_btn(B_NONE);
    chk("rs req before reset", {31'd0, wr_req}, 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk_reset_outputs("async reset");
    tick();
    @(negedge clk);
    reset = 1'b0;
    tick();
    pulse_chk("post reset crono", B_MODE, G_C, 1, 0);
    pulse_chk("post reset hora",  B_MODE, G_H, 5, 0);
    pulse_chk("post reset day",   B_MODE, G_F, 8, 1);
    pulse_chk("post reset month", B_RT,   G_F, 9, 1);
    pulse_chk("post reset year",  B_RT,   G_F, 10, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_edit_controller.md
# rtc_edit_controller

Controller for the RTC front-panel editing path. It owns the edit mode (chronometer, time, or date group) and the cursor address within the active group. It holds a shadow copy of the ten editable fields and applies up/down edits with per-field wrap-around. On save it commits the active group to the RTC bus interface through a req/ack write handshake. It sits between the debounced push-button pulses and the RTC read/write interface, and drives the position/highlight logic and the display.

## Interface
Parameters:
- none (field map and limits are fixed, see Operation)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- btn_mode  in  1  one-cycle pulse: advance edit group
- btn_left  in  1  one-cycle pulse: cursor to previous field in group
- btn_right  in  1  one-cycle pulse: cursor to next field in group
- btn_up  in  1  one-cycle pulse: increment field at cursor
- btn_down  in  1  one-cycle pulse: decrement field at cursor
- btn_save  in  1  one-cycle pulse: commit active group
- load_valid  in  1  shadow load strobe from RTC read path
- load_addr  in  8  field address to load (1..10)
- load_data  in  8  binary field value
- wr_ack  in  1  RTC interface accepted current write
- wr_req  out  1  write request
- wr_addr  out  8  field address being written
- wr_data  out  8  binary value being written
- camb_crono  out  1  chronometer group being edited
- camb_hora  out  1  time group being edited
- camb_fecha  out  1  date group being edited
- cursor_addr  out  8  current field address (0 when idle)
- field_data  out  8  shadow value at cursor_addr (0 when idle)
- busy  out  1  commit sequence in progress

## Operation
Field map, all values are binary, with inclusive min..max:
- Chronometer: 1 hours 0..23, 2 min 0..59, 3 sec 0..59, 4 centisec 0..99
- Time: 5 hours 0..23, 6 min 0..59, 7 sec 0..59
- Date: 8 day 1..31, 9 month 1..12, 10 year 0..99
- Day max is 31 for every month; calendar validation lives elsewhere.

States:
- IDLE: no group active; all camb_* low; cursor_addr 0.
  - btn_mode → EDIT with group CRONO, cursor 1.
  - Shadow registers accept load_valid writes only in IDLE. Addresses outside 1..10 are ignored. Out-of-range data is clamped to the field max.
- EDIT: exactly one camb_* high.
  - btn_mode cycles CRONO→HORA→FECHA→IDLE. On each group change the cursor goes to that group's first address (1, 5, 8). Shadow edits are kept, not reverted.
  - btn_right: cursor +1, wrapping from the last field to the first (4→1, 7→5, 10→8). btn_left is the mirror (1→4, 5→7, 8→10).
  - btn_up: value +1, wrapping max→min. btn_down: value −1, wrapping min→max (0→59, 1→12, 1→31).
  - btn_save → COMMIT_REQ, with the write index at the group's first address.
- COMMIT_REQ: wr_req=1, with wr_addr/wr_data taken from the shadow; hold until wr_ack=1 is sampled.
  - On ack, if it was the group's last address → IDLE. Otherwise → COMMIT_GAP.
- COMMIT_GAP: wr_req=0 for one cycle, index +1, → COMMIT_REQ.

Rules:
- busy=1 in COMMIT_REQ and COMMIT_GAP. All buttons and load_valid are ignored while busy.
- Simultaneous pulses in EDIT: only one action per cycle, priority save > mode > up > down > right > left. Lower-priority pulses that cycle are dropped.
- Shadow reset values: 0 for all fields, except day=1 and month=1.
- Reset mid-commit: wr_req drops asynchronously, state returns to IDLE, and the shadow reinitialises. No partial-commit recovery.

## Timing
- All outputs are registered.
- Reset values: wr_req 0, wr_addr 0, wr_data 0, camb_* 0, cursor_addr 0, field_data 0, busy 0.
- Button pulse sampled at edge n → updated cursor_addr/field_data/camb_* visible after edge n (1-cycle latency).
- btn_save at edge n → wr_req=1 and busy=1 after edge n.
- wr_addr/wr_data are stable for the whole time wr_req=1. They may change only in the cycle after ack.
- wr_ack sampled at edge m with wr_req=1 → wr_req=0 after edge m. wr_ack is ignored when wr_req=0.
- Commit cost is 2 cycles per field minimum, i.e. 2N−1 cycles plus ack wait. With immediate ack, a time-group commit spans 5 cycles of busy.
- load_valid with the same address on consecutive cycles: the last value wins.

## Test plan
- Reset, then mode ×1, then up ×3 → camb_crono=1, cursor_addr=1, field_data=3. Then mode ×3 → all camb_* 0, cursor_addr 0.
- Load addr 6 = 59, mode ×2 (HORA), right, up → field_data=0 (wrap). Down → 59. Left from 5 → cursor 7.
- FECHA, cursor 9 = 1, down → 12. Cursor 8 = 31, up → 1. load_valid during EDIT with addr 8 = 20 → value unchanged.
- HORA, save with ack delayed 3 cycles per write → writes (5,v5),(6,v6),(7,v7) in order. Each has addr/data stable while req=1 and one idle cycle between; the sequence ends in IDLE with busy=0.
- In EDIT, pulse up+down+right in the same cycle → only +1 applied, cursor unchanged. btn_mode during busy → ignored.
- Assert reset while wr_req=1 awaiting ack → wr_req=0 immediately, all outputs at reset values, day=1 and month=1 afterwards.
